// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the class FIFO family.
// Holds the default geometry and the occupancy-width derivation.
package fifo_pkg;

    localparam int DEF_DATA_SIZE = 6;
    localparam int DEF_ADDR_SIZE = 2;

    // Occupancy must represent 0..DEPTH inclusive, so it needs one bit more than the pointer.
    function automatic int cnt_w(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_hyst_if.sv
// FIFO request/response and status bundle between the class demux, the FIFO and the arbiter.
interface fifo_sync_hyst_if
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
    localparam int CNT_W = cnt_w(ADDR_SIZE);

    logic                 push;
    logic                 pop;
    logic [DATA_SIZE-1:0] data_in;
    logic [CNT_W-1:0]     af_thr;
    logic [CNT_W-1:0]     ae_thr;
    logic                 err_clr;
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 full;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 pause;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output push, pop, data_in, af_thr, ae_thr, err_clr,
        input  data_out, data_valid, count, empty, full, almost_full,
               almost_empty, pause, err_overflow, err_underflow
    );

    modport slave (
        input  push, pop, data_in, af_thr, ae_thr, err_clr,
        output data_out, data_valid, count, empty, full, almost_full,
               almost_empty, pause, err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_mem_dp.sv
// FIFO storage: one write port, one registered read port with enable.
module fifo_mem_dp #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

    // NOTE: storage is deliberately left out of reset; stale words are unreachable
    // because the pointers and count are reset, and this keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A read and a write to the same address return the old word (full push+pop case).
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_sync_hyst.sv
// Single-clock FIFO with occupancy thresholds, hysteretic pause and sticky error flags.
module fifo_sync_hyst
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    fifo_sync_hyst_if.slave   bus
);
    localparam int CNT_W = cnt_w(ADDR_SIZE);
    localparam int DEPTH = 2**ADDR_SIZE;

    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_next;
    logic                 pop_ok, push_ok;
    logic                 empty, full;
    logic                 data_valid, pause, err_overflow, err_underflow;
    logic [DATA_SIZE-1:0] rd_data;

    // Flags come from the registered count only, so push/pop never glitch them.
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign pop_ok     = bus.pop & ~empty;
    assign push_ok    = bus.push & (~full | pop_ok);
    assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

    fifo_mem_dp #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values and the evaluation order of always_ff blocks is irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            data_valid    <= 1'b0;
            pause         <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            data_valid <= pop_ok;

            // Set has priority, so overlapping thresholds keep pause asserted.
            if (count_next >= bus.af_thr)      pause <= 1'b1;
            else if (count_next <= bus.ae_thr) pause <= 1'b0;

            // A fresh error in the clear cycle keeps its flag set.
            err_overflow  <= (bus.push & ~push_ok) | (err_overflow  & ~bus.err_clr);
            err_underflow <= (bus.pop  & ~pop_ok)  | (err_underflow & ~bus.err_clr);
        end
    end

    assign bus.data_out      = rd_data;
    assign bus.data_valid    = data_valid;
    assign bus.count         = count;
    assign bus.empty         = empty;
    assign bus.full          = full;
    assign bus.almost_full   = (count >= bus.af_thr);
    assign bus.almost_empty  = (count <= bus.ae_thr) && !empty;
    assign bus.pause         = pause;
    assign bus.err_overflow  = err_overflow;
    assign bus.err_underflow = err_underflow;
endmodule
